// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, opcode constants, PC width.
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    LATCH = 2'd2,
    EXEC  = 2'd3
  } fetch_state_t;

  localparam logic [3:0] OP_JCOND = 4'h4;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [7:0] OP_JAL   = 8'h48;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer feeding the PC displacement unit.
// One instruction takes MEM_LAT+2 cycles: FETCH, (MEM_LAT-1) x WAIT, LATCH, EXEC.
import cpu_pkg::*;

module pc_fetch_ctrl #(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     MEM_LAT  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [PC_W-1:0] next_pc,
  input  logic [PC_W-1:0] link_in,
  input  logic [15:0]     mem_rdata,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     ir_out,
  output logic [7:0]      op_out,
  output logic [PC_W-1:0] link_out,
  output logic            link_we,
  output logic            instr_done,
  output logic [1:0]      state_out
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  fetch_state_t    state, state_nx;
  logic [2:0]      cnt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            advance;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (!stall) state_nx = (MEM_LAT > 1) ? WAIT : LATCH;
      WAIT:    if (cnt == 3'd1) state_nx = LATCH;
      LATCH:   state_nx = EXEC;
      EXEC:    if (!stall) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Strobes are gated by reset so they read low during the reset cycle itself.
  always_comb begin
    mem_rd     = 1'b0;
    advance    = 1'b0;
    if (!reset) begin
      mem_rd  = (state == FETCH) && !stall;
      advance = (state == EXEC) && !stall;
    end
    instr_done = advance;
    link_we    = advance && (op_out == OP_JAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      link_out <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        FETCH: if (!stall && (MEM_LAT > 1)) cnt <= CNT_INIT;
        WAIT:  cnt <= cnt - 3'd1;
        LATCH: ir  <= mem_rdata;
        EXEC: begin
          if (!stall) begin
            pc <= next_pc;
            if (op_out == OP_JAL) link_out <= link_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out    = pc;
  assign mem_addr  = pc;
  assign ir_out    = ir;
  assign op_out    = {ir[15:12], ir[7:4]};
  assign state_out = state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl at memory latencies 1, 3 and 4.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance a: MEM_LAT=1
  logic        rst_a = 1'b1, stall_a = 1'b0, tie_a = 1'b0;
  logic [15:0] np_drv_a = '0, np_a, lk_a = '0, rdata_a = '0;
  logic [15:0] addr_a, pc_a, ir_a, link_a;
  logic [7:0]  op_a;
  logic        rd_a, lwe_a, done_a;
  logic [1:0]  st_a;
  assign np_a = tie_a ? pc_a + 16'd1 : np_drv_a;

  // Instance b: MEM_LAT=3, memory model returns data exactly 3 cycles after mem_rd
  logic        rst_b = 1'b1;
  logic [15:0] np_b, rdata_b, addr_b, pc_b, ir_b, link_b;
  logic [7:0]  op_b;
  logic        rd_b, lwe_b, done_b;
  logic [1:0]  st_b;
  logic [2:0]  rsh_b = '0;
  logic [15:0] ash0 = '0, ash1 = '0, ash2 = '0;
  assign np_b    = pc_b + 16'd2;
  assign rdata_b = rsh_b[2] ? (16'h5000 ^ ash2) : 16'hBAD0;
  always @(posedge clk) begin
    rsh_b <= {rsh_b[1:0], rd_b};
    ash0  <= addr_b;
    ash1  <= ash0;
    ash2  <= ash1;
  end

  // Instance c: MEM_LAT=4
  logic        rst_c = 1'b1;
  logic [15:0] np_c = 16'h0040, lk_c = '0, rdata_c = 16'h7777;
  logic [15:0] addr_c, pc_c, ir_c, link_c;
  logic [7:0]  op_c;
  logic        rd_c, lwe_c, done_c;
  logic [1:0]  st_c;

  pc_fetch_ctrl #(.RESET_PC(16'h0010), .MEM_LAT(1)) u_a (
    .clk(clk), .reset(rst_a), .stall(stall_a), .next_pc(np_a), .link_in(lk_a),
    .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_rd(rd_a), .pc_out(pc_a),
    .ir_out(ir_a), .op_out(op_a), .link_out(link_a), .link_we(lwe_a),
    .instr_done(done_a), .state_out(st_a));

  pc_fetch_ctrl #(.RESET_PC(16'h0010), .MEM_LAT(3)) u_b (
    .clk(clk), .reset(rst_b), .stall(1'b0), .next_pc(np_b), .link_in(16'h0000),
    .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_rd(rd_b), .pc_out(pc_b),
    .ir_out(ir_b), .op_out(op_b), .link_out(link_b), .link_we(lwe_b),
    .instr_done(done_b), .state_out(st_b));

  pc_fetch_ctrl #(.RESET_PC(16'h0010), .MEM_LAT(4)) u_c (
    .clk(clk), .reset(rst_c), .stall(1'b0), .next_pc(np_c), .link_in(lk_c),
    .mem_rdata(rdata_c), .mem_addr(addr_c), .mem_rd(rd_c), .pc_out(pc_c),
    .ir_out(ir_c), .op_out(op_c), .link_out(link_c), .link_we(lwe_c),
    .instr_done(done_c), .state_out(st_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_cmp++; if (pc_a !== 16'h0010) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", pc_a, 16'h0010); end
    n_cmp++; if (rd_a !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rd got=%b exp=0", rd_a); end
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", st_a); end
    n_cmp++; if (ir_a !== 16'h0000) begin n_bad++; $display("FAIL rst_ir got=%h exp=0000", ir_a); end
    n_cmp++; if (link_a !== 16'h0000) begin n_bad++; $display("FAIL rst_link got=%h exp=0000", link_a); end
    n_cmp++; if ({done_a, lwe_a} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses got=%b exp=00", {done_a, lwe_a}); end
    rst_a = 1'b0;
    #1;
    n_cmp++; if (rd_a !== 1'b1) begin n_bad++; $display("FAIL first_mem_rd got=%b exp=1", rd_a); end
    n_cmp++; if (addr_a !== 16'h0010) begin n_bad++; $display("FAIL first_addr got=%h exp=%h", addr_a, 16'h0010); end
  endtask

  task automatic test_sequential;
    logic [1:0]  exp_st;
    logic [15:0] exp_pc;
    tie_a   = 1'b1;
    rdata_a = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      exp_st = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd2 : 2'd3;
      exp_pc = 16'h0010 + 16'(i / 3);
      n_cmp++; if (st_a !== exp_st) begin n_bad++; $display("FAIL seq_state[%0d] got=%0d exp=%0d", i, st_a, exp_st); end
      n_cmp++; if (done_a !== (i % 3 == 2)) begin n_bad++; $display("FAIL seq_done[%0d] got=%b exp=%b", i, done_a, (i % 3 == 2)); end
      n_cmp++; if (pc_a !== exp_pc) begin n_bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_a, exp_pc); end
      tick();
    end
  endtask

  task automatic test_jal;
    tie_a    = 1'b0;
    np_drv_a = 16'h0200;
    lk_a     = 16'h0011;
    rdata_a  = 16'h4480;
    tick();
    tick();
    n_cmp++; if (ir_a !== 16'h4480) begin n_bad++; $display("FAIL jal_ir got=%h exp=4480", ir_a); end
    n_cmp++; if (op_a !== 8'h48) begin n_bad++; $display("FAIL jal_op got=%h exp=48", op_a); end
    n_cmp++; if (lwe_a !== 1'b1) begin n_bad++; $display("FAIL jal_link_we got=%b exp=1", lwe_a); end
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL jal_done got=%b exp=1", done_a); end
    n_cmp++; if (link_a !== 16'h0000) begin n_bad++; $display("FAIL jal_link_early got=%h exp=0000", link_a); end
    tick();
    n_cmp++; if (link_a !== 16'h0011) begin n_bad++; $display("FAIL jal_link got=%h exp=0011", link_a); end
    n_cmp++; if (lwe_a !== 1'b0) begin n_bad++; $display("FAIL jal_link_we_end got=%b exp=0", lwe_a); end
    n_cmp++; if (addr_a !== 16'h0200) begin n_bad++; $display("FAIL jal_next_addr got=%h exp=0200", addr_a); end
    n_cmp++; if (rd_a !== 1'b1) begin n_bad++; $display("FAIL jal_next_rd got=%b exp=1", rd_a); end
  endtask

  task automatic test_stall;
    stall_a = 1'b1;
    #1;
    n_cmp++; if (rd_a !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_rd got=%b exp=0", rd_a); end
    tick();
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL fetch_stall_state got=%0d exp=0", st_a); end
    n_cmp++; if (rd_a !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_rd2 got=%b exp=0", rd_a); end
    stall_a  = 1'b0;
    rdata_a  = 16'h1234;
    np_drv_a = 16'h0300;
    tick();
    tick();
    stall_a = 1'b1;
    rdata_a = 16'hDEAD;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (st_a !== 2'd3) begin n_bad++; $display("FAIL exec_stall_state[%0d] got=%0d exp=3", i, st_a); end
      n_cmp++; if (pc_a !== 16'h0200) begin n_bad++; $display("FAIL exec_stall_pc[%0d] got=%h exp=0200", i, pc_a); end
      n_cmp++; if (ir_a !== 16'h1234) begin n_bad++; $display("FAIL exec_stall_ir[%0d] got=%h exp=1234", i, ir_a); end
      n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL exec_stall_done[%0d] got=%b exp=0", i, done_a); end
      if (i < 3) tick();
    end
    stall_a = 1'b0;
    #1;
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL unstall_done got=%b exp=1", done_a); end
    tick();
    n_cmp++; if (pc_a !== 16'h0300) begin n_bad++; $display("FAIL unstall_pc got=%h exp=0300", pc_a); end
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL unstall_state got=%0d exp=0", st_a); end
  endtask

  task automatic test_lat3;
    logic [1:0]  exp_st;
    logic [15:0] exp_pc;
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      case (i % 5)
        0:       exp_st = 2'd0;
        1, 2:    exp_st = 2'd1;
        3:       exp_st = 2'd2;
        default: exp_st = 2'd3;
      endcase
      exp_pc = 16'h0010 + 16'(2 * (i / 5));
      n_cmp++; if (st_b !== exp_st) begin n_bad++; $display("FAIL lat3_state[%0d] got=%0d exp=%0d", i, st_b, exp_st); end
      n_cmp++; if (done_b !== (i % 5 == 4)) begin n_bad++; $display("FAIL lat3_done[%0d] got=%b exp=%b", i, done_b, (i % 5 == 4)); end
      n_cmp++; if (pc_b !== exp_pc) begin n_bad++; $display("FAIL lat3_pc[%0d] got=%h exp=%h", i, pc_b, exp_pc); end
      if (i == 4) begin
        n_cmp++; if (ir_b !== 16'h5010) begin n_bad++; $display("FAIL lat3_ir0 got=%h exp=5010", ir_b); end
      end
      if (i == 9) begin
        n_cmp++; if (ir_b !== 16'h5012) begin n_bad++; $display("FAIL lat3_ir1 got=%h exp=5012", ir_b); end
      end
      tick();
    end
  endtask

  task automatic test_reset_in_wait;
    logic [1:0] exp_st;
    rst_c = 1'b0;
    #1;
    tick();
    n_cmp++; if (st_c !== 2'd1) begin n_bad++; $display("FAIL lat4_wait1 got=%0d exp=1", st_c); end
    tick();
    n_cmp++; if (st_c !== 2'd1) begin n_bad++; $display("FAIL lat4_wait2 got=%0d exp=1", st_c); end
    rst_c = 1'b1;
    tick();
    n_cmp++; if (st_c !== 2'd0) begin n_bad++; $display("FAIL wrst_state got=%0d exp=0", st_c); end
    n_cmp++; if (pc_c !== 16'h0010) begin n_bad++; $display("FAIL wrst_pc got=%h exp=0010", pc_c); end
    n_cmp++; if (ir_c !== 16'h0000) begin n_bad++; $display("FAIL wrst_ir got=%h exp=0000", ir_c); end
    n_cmp++; if (rd_c !== 1'b0) begin n_bad++; $display("FAIL wrst_rd got=%b exp=0", rd_c); end
    rst_c = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_st = (i == 0) ? 2'd0 : (i < 4) ? 2'd1 : (i == 4) ? 2'd2 : 2'd3;
      n_cmp++; if (st_c !== exp_st) begin n_bad++; $display("FAIL lat4_state[%0d] got=%0d exp=%0d", i, st_c, exp_st); end
      n_cmp++; if (ir_c !== ((i == 5) ? 16'h7777 : 16'h0000)) begin n_bad++; $display("FAIL lat4_ir[%0d] got=%h", i, ir_c); end
      n_cmp++; if (done_c !== (i == 5)) begin n_bad++; $display("FAIL lat4_done[%0d] got=%b exp=%b", i, done_c, (i == 5)); end
      tick();
    end
    n_cmp++; if (pc_c !== 16'h0040) begin n_bad++; $display("FAIL lat4_pc got=%h exp=0040", pc_c); end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_sequential();
    test_jal();
    test_stall();
    test_lat3();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer for the 16-bit CPU; sits directly upstream of the PC displacement unit.
- Holds the architectural PC, drives the instruction-memory read, latches the instruction register (IR), and presents pc/op/condition fields to the displacement unit.
- Loads the displacement unit's next-PC result back into the PC once per instruction.
- Captures the link value on JAL.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_LAT, 1, instruction-memory read latency in cycles (legal range 1..7).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  downstream busy; freezes FETCH and EXEC states
- next_pc  in  16  next PC from displacement unit (dis_out)
- link_in  in  16  return address from displacement unit (link_out)
- mem_rdata  in  16  instruction word from instruction memory
- mem_addr  out  16  instruction-memory address (always equals pc_out)
- mem_rd  out  1  read strobe, one cycle per fetch
- pc_out  out  16  current PC, to displacement unit pc_in
- ir_out  out  16  latched instruction, also drives displacement condition input
- op_out  out  8  {ir[15:12], ir[7:4]}, to displacement op input
- link_out  out  16  registered return address
- link_we  out  1  one-cycle pulse when link_out updates
- instr_done  out  1  one-cycle pulse in the cycle the PC advances
- state_out  out  2  current FSM state, for debug

Behaviour:
- Reset (synchronous, reset high at rising edge): pc=RESET_PC, ir=0, link_out=0, link_we=0, instr_done=0, mem_rd=0, latency counter=0, state=FETCH. Reset has priority over stall and every state; mid-fetch reset discards in-flight read data.
- State encoding: FETCH=0, WAIT=1, LATCH=2, EXEC=3.
- FETCH:
  - mem_rd=1 only while stall=0; state held while stall=1.
  - With stall=0: go to WAIT with cnt=MEM_LAT-1 if MEM_LAT>1, else go to LATCH.
- WAIT: decrement cnt; move to LATCH when cnt==1. stall is ignored.
- LATCH:
  - mem_rdata is valid exactly MEM_LAT cycles after the mem_rd cycle.
  - At the edge: ir <= mem_rdata, then go to EXEC. stall is ignored.
- EXEC, stall=1: hold state; pc, ir and link_out unchanged.
- EXEC, stall=0, at the edge:
  - pc <= next_pc; instr_done=1 for this cycle; go to FETCH.
  - If op_out==8'h48 (JAL): link_out <= link_in and link_we=1 for this cycle.
- Latency: one instruction takes MEM_LAT+2 cycles with no stall (3 cycles at MEM_LAT=1).
- mem_addr and pc_out stay stable from FETCH through EXEC. The PC changes only at the EXEC edge.
- next_pc is taken unmodified. 16'hFFFF -> 16'h0000 wrap is the displacement unit's responsibility; this block performs no range check.
- instr_done and link_we are registered-state decodes: high only during the EXEC cycle that advances.
- An illegal state value recovers to FETCH.
- Outputs op_out and ir_out are combinational slices of the ir register, with no extra latency.

Decomposition:
- Shared package cpu_pkg:
  - fetch state constants (FETCH, WAIT, LATCH, EXEC)
  - opcode constants OP_JCOND=4'h4, OP_BCOND=4'hC, OP_JAL=8'h48
  - PC width constant 16
- No sub-module. The latency counter is a 3-bit register inside this block.

Test Plan:
- Reset with RESET_PC=16'h0010 -> pc_out=16'h0010, mem_rd=0 during reset. First post-reset cycle: mem_rd=1, mem_addr=16'h0010.
- MEM_LAT=1, next_pc tied to pc_out+1, mem_rdata=16'h0000 -> instr_done every 3rd cycle; pc steps 0x0010, 0x0011, 0x0012.
- MEM_LAT=3, mem_rdata valid only 3 cycles after mem_rd -> ir_out captures the delayed word; instr_done period is 5 cycles.
- JAL: mem_rdata=16'h4480 (op_out=8'h48), link_in=16'h0011, next_pc=16'h0200 -> link_we pulse, link_out=16'h0011, next fetch address 16'h0200.
- stall=1 for 4 cycles in EXEC -> pc, ir_out and state_out=3 held, no instr_done. Advance on the first cycle with stall=0. Stall in FETCH -> mem_rd stays 0.
- Reset asserted in WAIT (MEM_LAT=4) -> next cycle state_out=0, pc=RESET_PC, ir_out=0. Stale mem_rdata is never latched.
